// File: rtl/cram_macro_seq.sv
// Expands one vector macro command into a stream of bit-serial CRam instruction
// words, one per cycle, re-issuing any word that the host's SRAM write displaced.
module cram_macro_seq #(
    parameter int Col      = 256,
    parameter int MaxWidth = 32,
    parameter int TmpCol   = 255,
    parameter int AddrW    = $clog2(Col)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_op_i,
    input  logic [AddrW-1:0] cmd_a_i,
    input  logic [AddrW-1:0] cmd_b_i,
    input  logic [AddrW-1:0] cmd_d_i,
    input  logic [5:0]       cmd_width_i,
    input  logic             cmd_pred_i,
    input  logic             cmd_cout_i,
    input  logic             host_we_i,
    output logic [31:0]      inst_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);
    localparam int ExtW = AddrW + 2;

    typedef enum logic [2:0] {IDLE, PRE, BODY, BODY2, POST} state_e;
    localparam logic [2:0] OpAnd = 3'd0, OpOr = 3'd1, OpXor = 3'd2, OpCpy = 3'd3,
                           OpNot = 3'd4, OpAdd = 3'd5, OpSub = 3'd6, OpRsv = 3'd7;
    localparam logic [3:0] CrCpy = 4'd7, CrInv = 4'd8, CrAdd = 4'd6, CrStc = 4'd11,
                           CrSc = 4'd13, CrCc = 4'd14;

    state_e             state_q, state_d;
    logic [4:0]         idx_q, idx_d;
    logic [31:0]        inst_q, inst_d;
    logic               done_q, done_d, err_q, err_d, latch;
    logic [2:0]         op_q, op_s;
    logic [AddrW-1:0]   a_q, b_q, d_q, a_s, b_s, d_s;
    logic [5:0]         w_q, w_s;
    logic               pred_q, cout_q, pred_s, cout_s;

    logic               arith, uses_b, cmd_ok, stall, last;
    logic [ExtW-1:0]    a_end, b_end, d_end, tmp;
    logic [3:0]         opc;
    logic [AddrW-1:0]   fa, fb, fd;

    // Range checks use widened sums so nothing wraps before the compare.
    always_comb begin
        arith  = (cmd_op_i == OpAdd) || (cmd_op_i == OpSub);
        uses_b = (cmd_op_i <= OpXor) || arith;
        tmp    = ExtW'(TmpCol);
        a_end  = ExtW'(cmd_a_i) + ExtW'(cmd_width_i);
        b_end  = ExtW'(cmd_b_i) + ExtW'(cmd_width_i);
        d_end  = ExtW'(cmd_d_i) + ExtW'(cmd_width_i);
        cmd_ok = 1'b1;
        if (cmd_width_i == 6'd0 || 32'(cmd_width_i) > MaxWidth) cmd_ok = 1'b0;
        if (cmd_op_i == OpRsv) cmd_ok = 1'b0;
        if (a_end > ExtW'(Col)) cmd_ok = 1'b0;
        if (uses_b && b_end > ExtW'(Col)) cmd_ok = 1'b0;
        if (d_end + ExtW'(arith & cmd_cout_i) > ExtW'(Col)) cmd_ok = 1'b0;
        if (cmd_op_i == OpSub &&
            ((tmp >= ExtW'(cmd_a_i) && tmp < a_end) ||
             (tmp >= ExtW'(cmd_b_i) && tmp < b_end) ||
             (tmp >= ExtW'(cmd_d_i) && tmp < d_end)))
            cmd_ok = 1'b0;
    end

    // In IDLE the word being built comes straight from the command inputs.
    always_comb begin
        op_s   = (state_q == IDLE) ? cmd_op_i    : op_q;
        a_s    = (state_q == IDLE) ? cmd_a_i     : a_q;
        b_s    = (state_q == IDLE) ? cmd_b_i     : b_q;
        d_s    = (state_q == IDLE) ? cmd_d_i     : d_q;
        w_s    = (state_q == IDLE) ? cmd_width_i : w_q;
        pred_s = (state_q == IDLE) ? cmd_pred_i  : pred_q;
        cout_s = (state_q == IDLE) ? cmd_cout_i  : cout_q;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        inst_d  = inst_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        latch   = 1'b0;
        opc     = 4'd0;
        fa      = '0;
        fb      = '0;
        fd      = '0;
        stall   = host_we_i && inst_q[31];
        last    = (6'({1'b0, idx_q}) + 6'd1) == w_q;
        if (!stall) begin
            unique case (state_q)
                IDLE: if (cmd_valid_i) begin
                    if (!cmd_ok) err_d = 1'b1;
                    else begin
                        latch   = 1'b1;
                        idx_d   = '0;
                        state_d = (cmd_op_i == OpAdd || cmd_op_i == OpSub) ? PRE : BODY;
                    end
                end
                PRE:  state_d = BODY;
                BODY, BODY2: begin
                    if (state_q == BODY && op_q == OpSub) state_d = BODY2;
                    else if (!last) begin
                        idx_d   = idx_q + 5'd1;
                        state_d = BODY;
                    end else if ((op_q == OpAdd || op_q == OpSub) && cout_q) state_d = POST;
                    else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                POST: begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
                default: state_d = IDLE;
            endcase

            unique case (state_d)
                PRE:  opc = (op_s == OpSub) ? CrSc : CrCc;
                BODY: begin
                    fa = a_s + AddrW'(idx_d);
                    fd = d_s + AddrW'(idx_d);
                    unique case (op_s)
                        OpCpy:   opc = CrCpy;
                        OpNot:   opc = CrInv;
                        OpAdd:   begin opc = CrAdd; fb = b_s + AddrW'(idx_d); end
                        OpSub:   begin opc = CrInv; fa = b_s + AddrW'(idx_d); fd = AddrW'(TmpCol); end
                        default: begin opc = {1'b0, op_s}; fb = b_s + AddrW'(idx_d); end
                    endcase
                end
                BODY2: begin
                    opc = CrAdd;
                    fa  = a_s + AddrW'(idx_d);
                    fb  = AddrW'(TmpCol);
                    fd  = d_s + AddrW'(idx_d);
                end
                POST:    begin opc = CrStc; fd = d_s + AddrW'(w_s); end
                default: opc = 4'd0;
            endcase
            inst_d = (state_d == IDLE) ? 32'h0 : {1'b1, 2'b00, pred_s, opc, fa, fb, fd};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            inst_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            w_q     <= '0;
            pred_q  <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            inst_q  <= inst_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (latch) begin
                op_q   <= cmd_op_i;
                a_q    <= cmd_a_i;
                b_q    <= cmd_b_i;
                d_q    <= cmd_d_i;
                w_q    <= cmd_width_i;
                pred_q <= cmd_pred_i;
                cout_q <= cmd_cout_i;
            end
        end
    end

    assign inst_o      = inst_q;
    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_cram_macro_seq.sv
// Bench for cram_macro_seq: fixed vectors plus random commands checked against a
// word-list model built from the macro expansion rules.
module tb_cram_macro_seq;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [2:0]  cmd_op_i = '0;
    logic [7:0]  cmd_a_i = '0, cmd_b_i = '0, cmd_d_i = '0;
    logic [5:0]  cmd_width_i = '0;
    logic        cmd_pred_i = 1'b0, cmd_cout_i = 1'b0, host_we_i = 1'b0;
    logic [31:0] inst_o;
    logic        busy_o, done_o, err_o;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];

    cram_macro_seq dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i), .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i), .cmd_d_i(cmd_d_i),
        .cmd_width_i(cmd_width_i), .cmd_pred_i(cmd_pred_i), .cmd_cout_i(cmd_cout_i),
        .host_we_i(host_we_i), .inst_o(inst_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] mk(input int p, input int opc, input int a, input int b, input int d);
        return {1'b1, 2'b00, 1'(p), 4'(opc), 8'(a), 8'(b), 8'(d)};
    endfunction

    // Expected word list for a legal command.
    function automatic void build_exp(input int op, input int a, input int b, input int d,
                                      input int w, input int p, input int c);
        exp_q.delete();
        if (op == 5) exp_q.push_back(mk(p, 14, 0, 0, 0));
        if (op == 6) exp_q.push_back(mk(p, 13, 0, 0, 0));
        for (int i = 0; i < w; i++) begin
            case (op)
                0, 1, 2: exp_q.push_back(mk(p, op, a + i, b + i, d + i));
                3:       exp_q.push_back(mk(p, 7, a + i, 0, d + i));
                4:       exp_q.push_back(mk(p, 8, a + i, 0, d + i));
                5:       exp_q.push_back(mk(p, 6, a + i, b + i, d + i));
                default: begin
                    exp_q.push_back(mk(p, 8, b + i, 0, 255));
                    exp_q.push_back(mk(p, 6, a + i, 255, d + i));
                end
            endcase
        end
        if ((op == 5 || op == 6) && c != 0) exp_q.push_back(mk(p, 11, 0, 0, d + w));
    endfunction

    function automatic bit in_rng(input int x, input int w);
        return (255 >= x) && (255 < x + w);
    endfunction

    function automatic bit legal(input int op, input int a, input int b, input int d,
                                 input int w, input int c);
        bit ar = (op == 5 || op == 6);
        bit ub = (op <= 2) || ar;
        if (w == 0 || w > 32 || op == 7) return 0;
        if (a + w > 256) return 0;
        if (ub && b + w > 256) return 0;
        if (d + w + ((ar && c != 0) ? 1 : 0) > 256) return 0;
        if (op == 6 && (in_rng(a, w) || in_rng(b, w) || in_rng(d, w))) return 0;
        return 1;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready_o && n < 200) begin
            tick();
            n++;
        end
        if (!cmd_ready_o) begin
            bad++;
            $display("FAIL wait_ready: cmd_ready_o=%0b required 1 within 200 cycles", cmd_ready_o);
        end
    endtask

    task automatic drive(input int op, input int a, input int b, input int d,
                         input int w, input int p, input int c);
        cmd_op_i = 3'(op); cmd_a_i = 8'(a); cmd_b_i = 8'(b); cmd_d_i = 8'(d);
        cmd_width_i = 6'(w); cmd_pred_i = 1'(p); cmd_cout_i = 1'(c);
        cmd_valid_i = 1'b1;
    endtask

    // Issues a command and checks it produces exp_q, stalling word st_k for st_n cycles.
    task automatic run_cmd(input string nm, input int op, input int a, input int b, input int d,
                           input int w, input int p, input int c, input int st_k, input int st_n);
        wait_ready();
        drive(op, a, b, d, w, p, c);
        tick();
        cmd_valid_i = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            total++;
            if (inst_o !== exp_q[k] || done_o !== 1'b0 || busy_o !== 1'b1) begin
                bad++;
                $display("FAIL %s word%0d: inst_o=%h done=%0b busy=%0b required %h 0 1",
                         nm, k, inst_o, done_o, busy_o, exp_q[k]);
            end
            if (k == st_k) begin
                for (int s = 0; s < st_n; s++) begin
                    host_we_i = 1'b1;
                    tick();
                    total++;
                    if (inst_o !== exp_q[k] || done_o !== 1'b0) begin
                        bad++;
                        $display("FAIL %s stall%0d word%0d: inst_o=%h done=%0b required %h 0",
                                 nm, s, k, inst_o, done_o, exp_q[k]);
                    end
                end
                host_we_i = 1'b0;
            end
            tick();
        end
        total++;
        if (done_o !== 1'b1 || inst_o !== 32'h0 || cmd_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL %s done: done=%0b inst_o=%h ready=%0b required 1 0 1",
                     nm, done_o, inst_o, cmd_ready_o);
        end
        tick();
        total++;
        if (done_o !== 1'b0 || inst_o !== 32'h0) begin
            bad++;
            $display("FAIL %s after_done: done=%0b inst_o=%h required 0 0", nm, done_o, inst_o);
        end
    endtask

    task automatic run_reject(input string nm, input int op, input int a, input int b, input int d,
                              input int w, input int c);
        wait_ready();
        drive(op, a, b, d, w, 0, c);
        tick();
        cmd_valid_i = 1'b0;
        total++;
        if (err_o !== 1'b1 || inst_o !== 32'h0 || cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL %s reject: err=%0b inst_o=%h ready=%0b busy=%0b required 1 0 1 0",
                     nm, err_o, inst_o, cmd_ready_o, busy_o);
        end
        tick();
        total++;
        if (err_o !== 1'b0 || inst_o !== 32'h0 || done_o !== 1'b0) begin
            bad++;
            $display("FAIL %s reject_after: err=%0b inst_o=%h done=%0b required 0 0 0",
                     nm, err_o, inst_o, done_o);
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (inst_o !== 32'h0 || cmd_ready_o !== 1'b1 || busy_o !== 1'b0 ||
            done_o !== 1'b0 || err_o !== 1'b0) begin
            bad++;
            $display("FAIL reset: inst_o=%h ready=%0b busy=%0b done=%0b err=%0b required 0 1 0 0 0",
                     inst_o, cmd_ready_o, busy_o, done_o, err_o);
        end
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_vectors();
        exp_q = '{32'h8E000000, 32'h86000810, 32'h86010911, 32'h86020A12, 32'h86030B13, 32'h8B000014};
        run_cmd("add_vec", 5, 0, 8, 16, 4, 0, 1, -1, 0);
        exp_q = '{32'h8D000000, 32'h880600FF, 32'h8604FF0A, 32'h880700FF, 32'h8605FF0B};
        run_cmd("sub_vec", 6, 4, 6, 10, 2, 0, 0, -1, 0);
        exp_q = '{32'h92010203, 32'h92020304, 32'h92030405};
        run_cmd("xor_pred", 2, 1, 2, 3, 3, 1, 0, -1, 0);
    endtask

    task automatic test_stall();
        build_exp(3, 20, 0, 40, 4, 0, 0);
        run_cmd("cpy_stall", 3, 20, 0, 40, 4, 0, 0, 1, 2);
        host_we_i = 1'b1;
        tick();
        tick();
        total++;
        if (inst_o !== 32'h0 || cmd_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL idle_we: inst_o=%h ready=%0b required 0 1", inst_o, cmd_ready_o);
        end
        host_we_i = 1'b0;
    endtask

    task automatic test_reject();
        run_reject("w0", 0, 0, 0, 0, 0, 0);
        run_reject("op7", 7, 0, 0, 0, 4, 0);
        run_reject("a_ovf", 3, 250, 0, 0, 8, 0);
        run_reject("sub_tmp", 6, 0, 8, 252, 4, 0);
        run_reject("w33", 0, 0, 0, 0, 33, 0);
        run_reject("add_cout_ovf", 5, 0, 8, 252, 4, 1);
    endtask

    task automatic test_back_to_back();
        wait_ready();
        drive(3, 5, 0, 9, 1, 0, 0);
        tick();
        drive(4, 6, 0, 11, 1, 0, 0);
        total++;
        if (inst_o !== mk(0, 7, 5, 0, 9) || cmd_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_w1: inst_o=%h ready=%0b required %h 0", inst_o, cmd_ready_o, mk(0, 7, 5, 0, 9));
        end
        tick();
        total++;
        if (done_o !== 1'b1 || inst_o !== 32'h0 || cmd_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL b2b_done: done=%0b inst_o=%h ready=%0b required 1 0 1", done_o, inst_o, cmd_ready_o);
        end
        tick();
        cmd_valid_i = 1'b0;
        total++;
        if (inst_o !== mk(0, 8, 6, 0, 11)) begin
            bad++;
            $display("FAIL b2b_w2: inst_o=%h required %h", inst_o, mk(0, 8, 6, 0, 11));
        end
        tick();
        total++;
        if (done_o !== 1'b1 || inst_o !== 32'h0) begin
            bad++;
            $display("FAIL b2b_done2: done=%0b inst_o=%h required 1 0", done_o, inst_o);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        wait_ready();
        drive(6, 0, 40, 80, 8, 0, 1);
        tick();
        cmd_valid_i = 1'b0;
        tick();
        tick();
        rst_ni = 1'b0;
        #1;
        total++;
        if (inst_o !== 32'h0 || cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid: inst_o=%h ready=%0b busy=%0b required 0 1 0", inst_o, cmd_ready_o, busy_o);
        end
        tick();
        rst_ni = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            total++;
            if (inst_o !== 32'h0 || done_o !== 1'b0) begin
                bad++;
                $display("FAIL rst_quiet%0d: inst_o=%h done=%0b required 0 0", n, inst_o, done_o);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int op, a, b, d, w, p, c, k, n;
            op = $urandom_range(0, 7);
            w  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 40) : $urandom_range(1, 32);
            a  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 200);
            b  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 200);
            d  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 200);
            p  = $urandom_range(0, 1);
            c  = $urandom_range(0, 1);
            if (op == 6 && c != 0 && d + w == 255) d = 0;
            if (legal(op, a, b, d, w, c)) begin
                build_exp(op, a, b, d, w, p, c);
                k = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, exp_q.size() - 1);
                n = $urandom_range(1, 3);
                run_cmd($sformatf("rnd%0d_op%0d", it, op), op, a, b, d, w, p, c, k, n);
            end else begin
                run_reject($sformatf("rnd%0d_op%0d", it, op), op, a, b, d, w, c);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_stall();
        test_reject();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
